// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Fetch-unit bus bundle: instruction memory port, redirect port
//            and the fetch-to-decode valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
    parameter int IMW = 4,
    parameter int IW  = 32
);
    logic           fetch_en;
    logic [IMW-1:0] im_addr;
    logic           im_cs;
    logic [IW-1:0]  im_data;
    logic           redirect_valid;
    logic [IMW-1:0] redirect_pc;
    logic           if_valid;
    logic           if_ready;
    logic [IW-1:0]  if_instr;
    logic [IMW-1:0] if_pc;

    modport master (
        input  fetch_en,
        output im_addr,
        output im_cs,
        input  im_data,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        output fetch_en,
        input  im_addr,
        input  im_cs,
        output im_data,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : PC owner and fetch initiator; captures {pc, instruction} into a
//            2-entry in-order buffer drained by decode, with redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int             IMW      = 4,
    parameter int             IW       = 32,
    parameter logic [IMW-1:0] RESET_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    instruction_fetch_if.master    bus
);

    localparam logic [1:0] c_full = 2'd2;

    logic [IMW-1:0] r_pc;
    logic [1:0]     r_count;
    logic [IW-1:0]  r_instr [2];
    logic [IMW-1:0] r_ipc   [2];

    logic           w_push;
    logic           w_pop;
    logic           w_slot1;
    logic [1:0]     w_count_nxt;

    // Select never looks at if_ready: a full buffer stalls for one cycle
    // rather than creating a ready-to-select combinational path.
    assign w_push  = bus.fetch_en & ~bus.redirect_valid & (r_count != c_full);
    assign w_pop   = bus.if_valid & bus.if_ready;
    assign w_slot1 = (r_count == 2'd1) & ~w_pop;

    assign bus.im_addr  = r_pc;
    assign bus.im_cs    = w_push;
    assign bus.if_valid = (r_count != 2'd0) & ~bus.redirect_valid;
    assign bus.if_instr = (r_count != 2'd0) ? r_instr[0] : '0;
    assign bus.if_pc    = (r_count != 2'd0) ? r_ipc[0]   : '0;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_count    <= 2'd0;
            r_instr[0] <= '0;
            r_instr[1] <= '0;
            r_ipc[0]   <= '0;
            r_ipc[1]   <= '0;
        end else if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_pop && !w_push) begin
                r_instr[0] <= r_instr[1];
                r_ipc[0]   <= r_ipc[1];
            end
            // New word lands behind the head unless the head leaves this cycle.
            if (w_push) begin
                if (w_slot1) begin
                    r_instr[1] <= bus.im_data;
                    r_ipc[1]   <= r_pc;
                end else begin
                    r_instr[0] <= bus.im_data;
                    r_ipc[0]   <= r_pc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Directed self-checking bench for instruction_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem [16];
    int          n_checks;
    int          n_fail;

    instruction_fetch_if #(.IMW(4), .IW(32)) bus ();

    instruction_fetch #(.IMW(4), .IW(32), .RESET_PC(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.im_data = mem[bus.im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bus.fetch_en       = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 4'd0;
        rst_n              = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle's inputs just after the edge, leave 1ns to settle.
    task automatic cycle(input int fe, input int rdy, input int rv, input int rpc);
        @(posedge clk);
        #1;
        bus.fetch_en       = (fe != 0);
        bus.if_ready       = (rdy != 0);
        bus.redirect_valid = (rv != 0);
        bus.redirect_pc    = 4'(rpc);
        #1;
    endtask

    // Row: fe, rdy, rv, rpc | cs, addr, valid, head_present, head_pc
    task automatic test_reset();
        logic [41:0] got;
        rst_n = 1'b0;
        bus.fetch_en = 1'b0; bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 4'd0;
        #1;
        got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
        n_checks++;
        if (got !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_during: got=%h want=%h", got, 42'd0);
        end
        do_reset();
        cycle(0, 0, 0, 0);
        got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
        n_checks++;
        if (got !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_after: got=%h want=%h", got, 42'd0);
        end
    endtask

    task automatic test_stream();
        int t[5][9] = '{
            '{1,1,0,0, 1,0,0,0,0},
            '{1,1,0,0, 1,1,1,1,0},
            '{1,1,0,0, 1,2,1,1,1},
            '{1,1,0,0, 1,3,1,1,2},
            '{1,1,0,0, 1,4,1,1,3}};
        logic [41:0] got, exp;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(t[k][0], t[k][1], t[k][2], t[k][3]);
            got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
            exp = {1'(t[k][4]), 4'(t[k][5]), 1'(t[k][6]),
                   (t[k][7] != 0) ? 4'(t[k][8]) : 4'd0,
                   (t[k][7] != 0) ? mem[4'(t[k][8])] : 32'd0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stream c%0d: got=%h want=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int t[7][9] = '{
            '{1,0,0,0, 1,0,0,0,0},
            '{1,0,0,0, 1,1,1,1,0},
            '{1,0,0,0, 0,2,1,1,0},
            '{1,0,0,0, 0,2,1,1,0},
            '{1,1,0,0, 0,2,1,1,0},
            '{1,1,0,0, 1,2,1,1,1},
            '{1,1,0,0, 1,3,1,1,2}};
        logic [41:0] got, exp;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cycle(t[k][0], t[k][1], t[k][2], t[k][3]);
            got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
            exp = {1'(t[k][4]), 4'(t[k][5]), 1'(t[k][6]),
                   (t[k][7] != 0) ? 4'(t[k][8]) : 4'd0,
                   (t[k][7] != 0) ? mem[4'(t[k][8])] : 32'd0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL backpressure c%0d: got=%h want=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_wrap();
        int t[6][9] = '{
            '{1,1,1,14, 0,0,0,0,0},
            '{1,1,0,0,  1,14,0,0,0},
            '{1,1,0,0,  1,15,1,1,14},
            '{1,1,0,0,  1,0,1,1,15},
            '{1,1,0,0,  1,1,1,1,0},
            '{1,1,0,0,  1,2,1,1,1}};
        logic [41:0] got, exp;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(t[k][0], t[k][1], t[k][2], t[k][3]);
            got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
            exp = {1'(t[k][4]), 4'(t[k][5]), 1'(t[k][6]),
                   (t[k][7] != 0) ? 4'(t[k][8]) : 4'd0,
                   (t[k][7] != 0) ? mem[4'(t[k][8])] : 32'd0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrap c%0d: got=%h want=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_redirect_full();
        int t[8][9] = '{
            '{1,0,1,3, 0,0,0,0,0},
            '{1,0,0,0, 1,3,0,0,0},
            '{1,0,0,0, 1,4,1,1,3},
            '{1,0,0,0, 0,5,1,1,3},
            '{1,0,1,5, 0,5,0,1,3},
            '{1,1,0,0, 1,5,0,0,0},
            '{1,1,0,0, 1,6,1,1,5},
            '{1,1,0,0, 1,7,1,1,6}};
        logic [41:0] got, exp;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(t[k][0], t[k][1], t[k][2], t[k][3]);
            got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
            exp = {1'(t[k][4]), 4'(t[k][5]), 1'(t[k][6]),
                   (t[k][7] != 0) ? 4'(t[k][8]) : 4'd0,
                   (t[k][7] != 0) ? mem[4'(t[k][8])] : 32'd0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL redirect_full c%0d: got=%h want=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_fetch_disable();
        int t[7][9] = '{
            '{1,0,0,0, 1,0,0,0,0},
            '{1,0,0,0, 1,1,1,1,0},
            '{0,1,0,0, 0,2,1,1,0},
            '{0,1,0,0, 0,2,1,1,1},
            '{0,1,0,0, 0,2,0,0,0},
            '{1,1,0,0, 1,2,0,0,0},
            '{1,1,0,0, 1,3,1,1,2}};
        logic [41:0] got, exp;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cycle(t[k][0], t[k][1], t[k][2], t[k][3]);
            got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
            exp = {1'(t[k][4]), 4'(t[k][5]), 1'(t[k][6]),
                   (t[k][7] != 0) ? 4'(t[k][8]) : 4'd0,
                   (t[k][7] != 0) ? mem[4'(t[k][8])] : 32'd0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fetch_disable c%0d: got=%h want=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [41:0] got, exp;
        logic        found;
        do_reset();
        cycle(1, 1, 1, 6);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
        exp = {1'b1, 4'd7, 1'b1, 4'd6, mem[6]};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL async_setup: got=%h want=%h", got, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus.im_cs, bus.im_addr, bus.if_valid, bus.if_pc, bus.if_instr};
        exp = {1'b1, 4'd0, 1'b0, 4'd0, 32'd0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL async_assert: got=%h want=%h", got, exp);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(posedge clk);
            #2;
            found = bus.if_valid;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL async_first_timeout: got if_valid=0 want 1 within 4 cycles");
        end else begin
            got = {32'd0, 1'b0, bus.if_pc, 1'b0, 4'd0};
            exp = {32'd0, 1'b0, 4'd0, 1'b0, 4'd0};
            if ({bus.if_pc, bus.if_instr} !== {4'd0, mem[0]}) begin
                n_fail++;
                $display("FAIL async_first_pc: got pc=%0d instr=%h want pc=0 instr=%h",
                         bus.if_pc, bus.if_instr, mem[0]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h0000_46B3;
        mem[1] = 32'h0000_4633;
        mem[2] = 32'h0000_45B3;
        mem[3] = 32'h0000_44B3;
        mem[4] = 32'h0000_4333;
        mem[5] = 32'h40B6_06B3;
        mem[6] = 32'h00A0_0093;
        mem[7] = 32'h00B0_0113;
        rst_n              = 1'b1;
        bus.fetch_en       = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 4'd0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_redirect_full();
        test_fetch_disable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
